wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the stalling RV32I pipeline. It holds the MEM/WB pipeline register, extracts and extends load data, and selects the writeback value. It drives the register file write port (`dataW`, `rd`, `RegWEn`) and maintains the retired-instruction counter. Optionally it forwards the value being written to the decode-stage operand reads.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Only 32 is supported.
- `CNT_W`, 64: width of the retired-instruction counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall_i` in 1: hold the MEM/WB register.
- `flush_i` in 1: squash the incoming MEM instruction.
- `mem_valid_i` in 1: MEM stage holds a real instruction.
- `mem_pc_i` in 32: PC of the MEM instruction.
- `mem_alu_i` in 32: ALU result. Also the load byte address.
- `mem_rdata_i` in 32: raw aligned word from data memory.
- `mem_funct3_i` in 3: load type.
- `mem_rd_i` in 5: destination register.
- `mem_regwen_i` in 1: instruction writes `rd`.
- `mem_wbsel_i` in 2: writeback source. `00` ALU, `01` load, `10` PC+4, `11` ALU.
- `id_rs1_i`, `id_rs2_i` in 5: decode-stage source indices.
- `rf_data1_i`, `rf_data2_i` in 32: register file read data.
- `dataW_o` out 32: write data to the register file.
- `rd_o` out 5: write index.
- `RegWEn_o` out 1: write enable.
- `id_data1_o`, `id_data2_o` out 32: decode operands after optional bypass.
- `wb_valid_o` out 1: WB holds a valid instruction. Used by the hazard unit.
- `instret_o` out `CNT_W`: count of retired instructions.

## Operation
- Register update priority at each `posedge clk`: `rst` > `flush_i` > `stall_i` > load.
  - `rst`: all fields are 0 and `instret` is 0.
  - `flush_i`: `valid` goes to 0. The other fields are don't-care and are loaded normally. Flush wins over stall.
  - `stall_i`: all fields hold.
  - Otherwise the register captures the `mem_*` inputs.
- Load extraction, from registered `alu[1:0]` and `funct3`:
  - LB (`000`) and LBU (`100`): select the byte at offset `alu[1:0]`. LB sign-extends, LBU zero-extends.
  - LH (`001`) and LHU (`101`): select the halfword at offset `alu[1]`. `alu[0]` is ignored. LH sign-extends, LHU zero-extends.
  - LW (`010`) and any other `funct3`: pass the full word.
- Writeback value:
  - ALU selection: the registered ALU result.
  - Load selection: the extracted load data.
  - PC+4 selection: `pc + 4` modulo 2^32, so `FFFFFFFC` yields 0.
- `dataW_o` and `rd_o` always reflect the registered instruction.
- `RegWEn_o = valid & regwen & (rd != 0)`. A write to x0 is suppressed in this block.
- While stalled, the WB instruction re-asserts its write each cycle. This is idempotent.
- `instret` increments by 1 on cycles where `valid & !stall_i & !rst`. It wraps at 2^`CNT_W`.
- Reset values of outputs:
  - `dataW_o` = 0, `rd_o` = 0, `RegWEn_o` = 0, `wb_valid_o` = 0, `instret_o` = 0.
  - `id_data*_o` equal `rf_data*_i`.

## Timing
- MEM to WB latency is 1 cycle.
- `dataW_o`, `rd_o` and `RegWEn_o` are combinational from the MEM/WB register, in the same cycle. The register file commits at the next edge.
- The bypass path and the `id_data*_o` outputs are combinational, with no added latency.
- `rst` asserted mid-stall or mid-flush clears the register at that edge. `RegWEn_o` is 0 in the following cycle.
- `flush_i` and `stall_i` asserted together: the register takes `valid` = 0 at the edge.

## Configuration
- Macro: `WB_BYPASS_EN`.
- Defined:
  - `id_data1_o` = `dataW_o` when `RegWEn_o & (id_rs1_i == rd_o)`, otherwise `rf_data1_i`. `id_data2_o` follows the same rule with `rs2`.
  - The hazard unit needs no stall for the WB-to-ID distance.
- Undefined:
  - `id_data*_o` = `rf_data*_i` unconditionally.
  - The hazard unit must stall decode one extra cycle while `wb_valid_o` is high and `rd_o` matches `rs1` or `rs2`.
- Either way, `rs == 0` never bypasses, because `RegWEn_o` is 0 for x0.

## Structure
- Shared `riscv_pkg` holds:
  - enum `wb_sel_e`: `WB_ALU`, `WB_LOAD`, `WB_PC4`.
  - load `funct3` constants: `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
  - a struct `memwb_t` for the pipeline register fields.
- One sub-module, `load_align`, which is purely combinational. Inputs: word, offset, `funct3`. Output: extended data.
- The pipeline register, counter and bypass stay in `wb_stage`.

## Test plan
- Reset, then `mem_valid`=1 with ALU result `0x1234`, rd=5, regwen=1, wbsel=ALU → next cycle `dataW_o`=`0x00001234`, `rd_o`=5, `RegWEn_o`=1. `instret` increments to 1.
- Load with rdata=`0x80FF7F01`:
  - LB at offset 2 → `0xFFFFFFFF`.
  - LBU at offset 3 → `0x00000080`.
  - LH at offset 2 → `0xFFFF80FF`.
  - LHU at offset 0 → `0x00007F01`.
- wbsel=PC+4 with pc=`0xFFFFFFFC` → `dataW_o`=0. With rd=0 and regwen=1 → `RegWEn_o`=0.
- Stall for 3 cycles with a new MEM instruction presented → WB fields unchanged and `instret` frozen. Then flush+stall together → `wb_valid_o`=0 next cycle.
- With `WB_BYPASS_EN`: WB writes x7=`0xDEAD`, `id_rs1_i`=7, `rf_data1_i`=`0x1` → `id_data1_o`=`0xDEAD`. Without the macro → `0x1`.
- `rst` asserted during a valid load → `RegWEn_o`=0, `instret_o`=0 next cycle.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: writeback source selector, load funct3
// encodings and the MEM/WB pipeline register layout.
package riscv_pkg;

    // Writeback source selector; encoding 2'b11 is treated as ALU by consumers.
    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // MEM/WB pipeline register fields. wbsel is kept as raw bits so the
    // reserved 2'b11 encoding is carried without a lossy enum cast.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        regwen;
        logic [1:0]  wbsel;
    } memwb_t;

    localparam memwb_t MEMWB_ZERO = '{
        valid:  1'b0,
        pc:     32'h0000_0000,
        alu:    32'h0000_0000,
        rdata:  32'h0000_0000,
        funct3: 3'b000,
        rd:     5'd0,
        regwen: 1'b0,
        wbsel:  2'b00
    };

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: purely combinational extraction and sign/zero extension of
// load data from an aligned memory word.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword; halfword ignores offset[0].
    always_comb begin
        byte_s = word[7:0];
        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (offset[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
    end

    // Extend per load type; unknown encodings pass the whole word.
    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data = {24'h00_0000, byte_s};
            F3_LH:   data = {{16{half_s[15]}}, half_s};
            F3_LHU:  data = {16'h0000, half_s};
            F3_LW:   data = word;
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the stalling RV32I pipeline. Holds the MEM/WB
// register, selects the writeback value, drives the register file write port
// and counts retired instructions.
// Optional feature macro: WB_BYPASS_EN (forward the WB write to decode reads).
module wb_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mem_valid_i,
    input  logic [31:0]      mem_pc_i,
    input  logic [XLEN-1:0]  mem_alu_i,
    input  logic [XLEN-1:0]  mem_rdata_i,
    input  logic [2:0]       mem_funct3_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_regwen_i,
    input  logic [1:0]       mem_wbsel_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic [XLEN-1:0]  rf_data1_i,
    input  logic [XLEN-1:0]  rf_data2_i,
    output logic [XLEN-1:0]  dataW_o,
    output logic [4:0]       rd_o,
    output logic             RegWEn_o,
    output logic [XLEN-1:0]  id_data1_o,
    output logic [XLEN-1:0]  id_data2_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] instret_o
);

    memwb_t           memwb_r;
    memwb_t           memwb_next_s;
    logic [31:0]      load_data_s;
    logic [31:0]      pc4_s;
    logic [XLEN-1:0]  wb_data_s;
    logic             wen_s;
    logic [CNT_W-1:0] instret_r;

    // Pack the incoming MEM instruction; flush only squashes valid.
    always_comb begin
        memwb_next_s        = MEMWB_ZERO;
        memwb_next_s.pc     = mem_pc_i;
        memwb_next_s.alu    = mem_alu_i;
        memwb_next_s.rdata  = mem_rdata_i;
        memwb_next_s.funct3 = mem_funct3_i;
        memwb_next_s.rd     = mem_rd_i;
        memwb_next_s.regwen = mem_regwen_i;
        memwb_next_s.wbsel  = mem_wbsel_i;
        if (flush_i) begin
            memwb_next_s.valid = 1'b0;
        end else begin
            memwb_next_s.valid = mem_valid_i;
        end
    end

    // MEM/WB register: reset over flush over stall over normal load.
    always_ff @(posedge clk) begin
        if (rst) begin
            memwb_r <= MEMWB_ZERO;
        end else if (flush_i) begin
            memwb_r <= memwb_next_s;
        end else if (stall_i) begin
            memwb_r <= memwb_r;
        end else begin
            memwb_r <= memwb_next_s;
        end
    end

    // Retired-instruction counter; an instruction retires when WB is valid
    // and not held. Wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (memwb_r.valid && !stall_i) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    load_align u_load_align (
        .word   (memwb_r.rdata),
        .offset (memwb_r.alu[1:0]),
        .funct3 (memwb_r.funct3),
        .data   (load_data_s)
    );

    assign pc4_s = memwb_r.pc + 32'd4;

    // Writeback source mux; the reserved 2'b11 encoding selects the ALU.
    always_comb begin
        wb_data_s = memwb_r.alu;
        case (memwb_r.wbsel)
            WB_ALU:  wb_data_s = memwb_r.alu;
            WB_LOAD: wb_data_s = load_data_s;
            WB_PC4:  wb_data_s = pc4_s;
            default: wb_data_s = memwb_r.alu;
        endcase
    end

    // Write enable; writes to x0 never leave this stage.
    always_comb begin
        if (memwb_r.valid && memwb_r.regwen && (memwb_r.rd != 5'd0)) begin
            wen_s = 1'b1;
        end else begin
            wen_s = 1'b0;
        end
    end

    assign dataW_o    = wb_data_s;
    assign rd_o       = memwb_r.rd;
    assign RegWEn_o   = wen_s;
    assign wb_valid_o = memwb_r.valid;
    assign instret_o  = instret_r;

`ifdef WB_BYPASS_EN
    // Forward the value being written to decode reads of the same register.
    always_comb begin
        if (wen_s && (id_rs1_i == memwb_r.rd)) begin
            id_data1_o = wb_data_s;
        end else begin
            id_data1_o = rf_data1_i;
        end
        if (wen_s && (id_rs2_i == memwb_r.rd)) begin
            id_data2_o = wb_data_s;
        end else begin
            id_data2_o = rf_data2_i;
        end
    end
`else
    logic unused_rs_s;

    // No forwarding: decode operands come straight from the register file;
    // the hazard unit covers the WB-to-ID distance with a stall.
    always_comb begin
        id_data1_o  = rf_data1_i;
        id_data2_o  = rf_data2_i;
        unused_rs_s = ^{id_rs1_i, id_rs2_i};
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed steps push expected WB state to a
// scoreboard queue, which is popped and compared one cycle later.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall_i, flush_i, mem_valid_i;
    logic [31:0] mem_pc_i, mem_alu_i, mem_rdata_i;
    logic [2:0]  mem_funct3_i;
    logic [4:0]  mem_rd_i;
    logic        mem_regwen_i;
    logic [1:0]  mem_wbsel_i;
    logic [4:0]  id_rs1_i, id_rs2_i;
    logic [31:0] rf_data1_i, rf_data2_i;
    logic [31:0] dataW_o, id_data1_o, id_data2_o;
    logic [4:0]  rd_o;
    logic        RegWEn_o, wb_valid_o;
    logic [63:0] instret_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        valid;
        logic [63:0] instret;
    } exp_t;

    exp_t        sb[$];
    logic        m_valid = 1'b0;
    logic [63:0] m_instret = 64'd0;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i), .mem_alu_i(mem_alu_i),
        .mem_rdata_i(mem_rdata_i), .mem_funct3_i(mem_funct3_i), .mem_rd_i(mem_rd_i),
        .mem_regwen_i(mem_regwen_i), .mem_wbsel_i(mem_wbsel_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i),
        .dataW_o(dataW_o), .rd_o(rd_o), .RegWEn_o(RegWEn_o),
        .id_data1_o(id_data1_o), .id_data2_o(id_data2_o),
        .wb_valid_o(wb_valid_o), .instret_o(instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mem(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rdata, input logic [2:0] f3, input logic [4:0] rd,
                       input logic we, input logic [1:0] sel);
        mem_valid_i = v; mem_pc_i = pc; mem_alu_i = alu; mem_rdata_i = rdata;
        mem_funct3_i = f3; mem_rd_i = rd; mem_regwen_i = we; mem_wbsel_i = sel;
    endtask

    // One clock step: model the counter, push the expected WB state, clock,
    // then pop and compare.
    task automatic step(input string tag, input logic [31:0] e_data, input logic [4:0] e_rd,
                        input logic e_wen, input logic e_valid);
        exp_t e;
        exp_t got;
        if (rst) begin
            m_instret = 64'd0;
        end else if (m_valid && !stall_i) begin
            m_instret = m_instret + 64'd1;
        end
        m_valid = e_valid;
        e.data = e_data; e.rd = e_rd; e.wen = e_wen; e.valid = e_valid; e.instret = m_instret;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, ".dataW"},   {32'd0, dataW_o},    {32'd0, got.data});
            chk({tag, ".rd"},      {59'd0, rd_o},       {59'd0, got.rd});
            chk({tag, ".wen"},     {63'd0, RegWEn_o},   {63'd0, got.wen});
            chk({tag, ".valid"},   {63'd0, wb_valid_o}, {63'd0, got.valid});
            chk({tag, ".instret"}, instret_o,           got.instret);
        end
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; rf_data1_i = 32'h0000_0011; rf_data2_i = 32'h0000_0022;
        mem(1'b1, 32'h0000_0040, 32'h0000_5555, 32'h0, 3'd0, 5'd9, 1'b1, 2'b00);
        @(negedge clk);
        step("reset", 32'h0, 5'd0, 1'b0, 1'b0);
        chk("reset.id1", {32'd0, id_data1_o}, {32'd0, 32'h0000_0011});
        chk("reset.id2", {32'd0, id_data2_o}, {32'd0, 32'h0000_0022});
        rst = 1'b0;

        mem(1'b1, 32'h0000_0100, 32'h0000_1234, 32'h0, 3'd2, 5'd5, 1'b1, 2'b00);
        step("alu", 32'h0000_1234, 5'd5, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0104, 32'h0000_1002, 32'h80FF_7F01, 3'b000, 5'd6, 1'b1, 2'b01);
        step("lb2", 32'hFFFF_FFFF, 5'd6, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0108, 32'h0000_1003, 32'h80FF_7F01, 3'b100, 5'd6, 1'b1, 2'b01);
        step("lbu3", 32'h0000_0080, 5'd6, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_010C, 32'h0000_1001, 32'h80FF_7F01, 3'b000, 5'd6, 1'b1, 2'b01);
        step("lb1", 32'h0000_007F, 5'd6, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0110, 32'h0000_1002, 32'h80FF_7F01, 3'b001, 5'd8, 1'b1, 2'b01);
        step("lh2", 32'hFFFF_80FF, 5'd8, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0114, 32'h0000_1003, 32'h80FF_7F01, 3'b001, 5'd8, 1'b1, 2'b01);
        step("lh3", 32'hFFFF_80FF, 5'd8, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0118, 32'h0000_1000, 32'h80FF_7F01, 3'b101, 5'd8, 1'b1, 2'b01);
        step("lhu0", 32'h0000_7F01, 5'd8, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_011C, 32'h0000_1001, 32'h80FF_7F01, 3'b010, 5'd8, 1'b1, 2'b01);
        step("lw", 32'h80FF_7F01, 5'd8, 1'b1, 1'b1);
        mem(1'b1, 32'hFFFF_FFFC, 32'h0000_00AA, 32'h0, 3'd0, 5'd0, 1'b1, 2'b10);
        step("pc4wrap_x0", 32'h0000_0000, 5'd0, 1'b0, 1'b1);
        mem(1'b1, 32'h0000_0100, 32'h0000_00AA, 32'h0, 3'd0, 5'd3, 1'b1, 2'b10);
        step("pc4", 32'h0000_0104, 5'd3, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0100, 32'h0000_0BBB, 32'h0, 3'd0, 5'd3, 1'b1, 2'b11);
        step("sel11", 32'h0000_0BBB, 5'd3, 1'b1, 1'b1);
        mem(1'b1, 32'h0000_0100, 32'h0000_0CCC, 32'h0, 3'd0, 5'd4, 1'b0, 2'b00);
        step("noregwen", 32'h0000_0CCC, 5'd4, 1'b0, 1'b1);

        // Bypass of x7 into decode operands.
        mem(1'b1, 32'h0000_0200, 32'h0000_DEAD, 32'h0, 3'd0, 5'd7, 1'b1, 2'b00);
        step("x7", 32'h0000_DEAD, 5'd7, 1'b1, 1'b1);
        id_rs1_i = 5'd7; rf_data1_i = 32'h0000_0001; id_rs2_i = 5'd2; rf_data2_i = 32'h0000_0002;
        #1;
`ifdef WB_BYPASS_EN
        chk("byp.id1", {32'd0, id_data1_o}, {32'd0, 32'h0000_DEAD});
`else
        chk("byp.id1", {32'd0, id_data1_o}, {32'd0, 32'h0000_0001});
`endif
        chk("byp.id2", {32'd0, id_data2_o}, {32'd0, 32'h0000_0002});

        // Stall three cycles with a different MEM instruction presented.
        stall_i = 1'b1;
        mem(1'b1, 32'h0000_0300, 32'h0000_BEEF, 32'h0, 3'd0, 5'd12, 1'b1, 2'b00);
        step("stall1", 32'h0000_DEAD, 5'd7, 1'b1, 1'b1);
        step("stall2", 32'h0000_DEAD, 5'd7, 1'b1, 1'b1);
        step("stall3", 32'h0000_DEAD, 5'd7, 1'b1, 1'b1);
        flush_i = 1'b1;
        step("flush_stall", 32'h0000_BEEF, 5'd12, 1'b0, 1'b0);
        stall_i = 1'b0;
        mem(1'b1, 32'h0000_0400, 32'h0000_0777, 32'h0, 3'd0, 5'd13, 1'b1, 2'b00);
        step("flush", 32'h0000_0777, 5'd13, 1'b0, 1'b0);
        flush_i = 1'b0;

        // Valid load then reset during a valid load.
        mem(1'b1, 32'h0000_0500, 32'h0000_2000, 32'h1234_5678, 3'b010, 5'd14, 1'b1, 2'b01);
        step("load", 32'h1234_5678, 5'd14, 1'b1, 1'b1);
        step("load2", 32'h1234_5678, 5'd14, 1'b1, 1'b1);
        rst = 1'b1;
        step("rst_mid", 32'h0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;
        mem(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 5'd0, 1'b0, 2'b00);
        step("idle", 32'h0, 5'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
